systolic_array_sequencer: RTL

- Sequences one output-stationary N x N tile computation on the int8 MAC processing-element grid.
- Accepts a tile command carrying the reduction depth K and clears the array.
- Drives the array-wide enable and generates per-lane skewed operand-feed valids and indices for the A/B operand buffers.
- Holds the finished accumulators stable until the result consumer accepts them.
- Sits between the tile-level command interface and the PE grid plus its operand buffers.

---
 rtl/systolic_array_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/systolic_array_sequencer.sv
// ---------------------------------------------------------------------------
// systolic_array_sequencer
//
// Sequences one output-stationary N x N tile computation on the int8 MAC
// processing-element grid. A tile command carries the reduction depth K. The
// sequencer then runs four phases:
//   CLEAR : one-cycle clear pulse to every PE
//   RUN   : T = K + 2(N-1) enabled steps with skewed per-lane operand feeds
//   DONE  : accumulators held stable until the result consumer accepts them
//   IDLE  : ready for the next command (at least one cycle between tiles)
//
// Ports
//   clk         clock, all logic on the rising edge
//   reset       synchronous active-high reset, priority in every state
//   cmd_valid   tile command offered
//   cmd_ready   command accepted when high (IDLE only)
//   cmd_k       reduction depth K of the offered command (0 allowed)
//   stall       operand buffers not ready; freezes array and sequencing
//   arr_start   one-cycle clear pulse to every PE start input
//   arr_enable  array-wide PE enable
//   lane_valid  bit r: row r of A / column r of B carries a real operand
//   lane_k      lane r operand index at bits [r*KW +: KW], 0 when not valid
//   busy        high in every state except IDLE
//   res_valid   all PE outputs are final and stable
//   res_ready   result consumer accepts the tile
// ---------------------------------------------------------------------------
module systolic_array_sequencer #(
   parameter int N  = 4,
   parameter int KW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [KW-1:0]   cmd_k,
   input  logic            stall,
   output logic            arr_start,
   output logic            arr_enable,
   output logic [N-1:0]    lane_valid,
   output logic [N*KW-1:0] lane_k,
   output logic            busy,
   output logic            res_valid,
   input  logic            res_ready
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Skew depth: the far corner PE sees its operands 2(N-1) steps after lane 0.
   localparam logic [KW:0] SKEW = (KW+1)'(2 * (N - 1));
   localparam logic [KW:0] ONE  = (KW+1)'(1);

   state_t        state, state_nx;
   logic [KW:0]   t, t_nx;
   logic [KW-1:0] k_reg, k_nx;
   logic [KW:0]   k_ext;
   logic [KW:0]   t_last;

   assign k_ext = {1'b0, k_reg};
   // RUN is only entered with K >= 1, so T-1 never underflows.
   assign t_last = k_ext + SKEW - ONE;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         t     <= '0;
         k_reg <= '0;
      end else begin
         state <= state_nx;
         t     <= t_nx;
         k_reg <= k_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      t_nx       = t;
      k_nx       = k_reg;
      cmd_ready  = 1'b0;
      arr_start  = 1'b0;
      arr_enable = 1'b0;
      busy       = 1'b1;
      res_valid  = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               k_nx     = cmd_k;
               t_nx     = '0;
               state_nx = S_CLEAR;
            end
         end
         S_CLEAR: begin
            arr_start = 1'b1;
            t_nx      = '0;
            // An empty reduction leaves the freshly cleared (all-zero) results.
            state_nx  = (k_reg == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (!stall) begin
               arr_enable = 1'b1;
               t_nx       = t + ONE;
               if (t == t_last) state_nx = S_DONE;
            end
         end
         S_DONE: begin
            // Enable stays low so the PE accumulators hold; stall is irrelevant.
            res_valid = 1'b1;
            if (res_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Lane r is delayed by r enabled steps: it carries operand index t-r while
   // r <= t <= r+K-1, and the feeder injects zeros outside that window.
   always_comb begin
      logic [KW:0] off;
      off        = '0;
      lane_valid = '0;
      lane_k     = '0;
      if (arr_enable) begin
         for (int r = 0; r < N; r++) begin
            off = t - (KW+1)'(r);
            if ((t >= (KW+1)'(r)) && (off < k_ext)) begin
               lane_valid[r]        = 1'b1;
               lane_k[r*KW +: KW]   = off[KW-1:0];
            end
         end
      end
   end

endmodule
